// File: rtl/afifo_pkt_writer.sv
`default_nettype none
// ============================================================================
//  Module   : afifo_pkt_writer
//  Purpose  : Write-domain packet framer in front of a dual-clock FIFO.
//             Turns a valid/ready payload stream into frames of the form
//             header (sequence number), payload, trailer (XOR checksum).
//             Payloads longer than MAX_LEN beats are truncated: the trailer
//             is emitted after the MAX_LEN-th beat and the remaining beats
//             are discarded up to and including the last one.
//  Ports    : wclk_i / wrst_n_i   write clock, async active-low reset
//             s_valid_i, s_ready_o, s_data_i, s_last_i   payload stream
//             wen_o, wdata_o, wfull_i                    FIFO write port
//             pkt_cnt_o   trailers written (wraps)
//             trunc_o     one-cycle pulse per truncated packet
//             busy_o      framer active or output word pending
//  Revision : 1.0  initial release
// ============================================================================
module afifo_pkt_writer #(
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 16
) (
   input  logic             wclk_i,
   input  logic             wrst_n_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [WIDTH-1:0] s_data_i,
   input  logic             s_last_i,
   output logic             wen_o,
   output logic [WIDTH-1:0] wdata_o,
   input  logic             wfull_i,
   output logic [CNT_W-1:0] pkt_cnt_o,
   output logic             trunc_o,
   output logic             busy_o
);

   localparam int                LEN_W      = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0]  c_LEN_LAST = LEN_W'(MAX_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PAY  = 2'd1,
      ST_TRL  = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_is_trl;
   logic [WIDTH-1:0] r_seq;
   logic [WIDTH-1:0] r_csum;
   logic [LEN_W-1:0] r_len;
   logic             r_drop_pend;
   logic [CNT_W-1:0] r_pkt_cnt;
   logic             r_trunc;

   logic             w_accept;
   logic             w_can_load;
   logic             w_load;
   logic [WIDTH-1:0] w_load_data;
   logic             w_load_trl;
   logic             w_hdr;
   logic             w_beat;
   logic             w_trunc;
   logic             w_drop_set;
   logic             w_drop_clr;

   // The output register may reload in the same cycle its word is taken,
   // which is what gives one FIFO word per cycle without bubbles.
   assign w_accept   = r_out_valid & ~wfull_i;
   assign w_can_load = ~r_out_valid | w_accept;

   always_comb begin
      w_state_nxt = r_state;
      s_ready_o   = 1'b0;
      w_load      = 1'b0;
      w_load_data = r_out_data;
      w_load_trl  = 1'b0;
      w_hdr       = 1'b0;
      w_beat      = 1'b0;
      w_trunc     = 1'b0;
      w_drop_set  = 1'b0;
      w_drop_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_valid_i && w_can_load) begin
               w_load      = 1'b1;
               w_load_data = r_seq;
               w_hdr       = 1'b1;
               w_state_nxt = ST_PAY;
            end
         end
         ST_PAY: begin
            s_ready_o = w_can_load;
            if (s_valid_i && w_can_load) begin
               w_load      = 1'b1;
               w_load_data = s_data_i;
               w_beat      = 1'b1;
               if (s_last_i) begin
                  w_state_nxt = ST_TRL;
               end else if (r_len == c_LEN_LAST) begin
                  w_trunc     = 1'b1;
                  w_drop_set  = 1'b1;
                  w_state_nxt = ST_TRL;
               end
            end
         end
         ST_TRL: begin
            if (w_can_load) begin
               w_load      = 1'b1;
               w_load_data = r_csum;
               w_load_trl  = 1'b1;
               w_drop_clr  = 1'b1;
               w_state_nxt = r_drop_pend ? ST_DROP : ST_IDLE;
            end
         end
         ST_DROP: begin
            // Discarded beats never reach the FIFO, so fullness is irrelevant.
            s_ready_o = 1'b1;
            if (s_valid_i && s_last_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wclk_i or negedge wrst_n_i) begin
      if (!wrst_n_i) begin
         r_state      <= ST_IDLE;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_is_trl <= 1'b0;
         r_seq        <= '0;
         r_csum       <= '0;
         r_len        <= '0;
         r_drop_pend  <= 1'b0;
         r_pkt_cnt    <= '0;
         r_trunc      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_trunc <= w_trunc;

         if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_load_data;
            r_out_is_trl <= w_load_trl;
         end else if (w_accept) begin
            r_out_valid  <= 1'b0;
         end

         if (w_hdr) begin
            r_seq  <= r_seq + WIDTH'(1);
            r_csum <= '0;
            r_len  <= '0;
         end else if (w_beat) begin
            r_csum <= r_csum ^ s_data_i;
            r_len  <= r_len + LEN_W'(1);
         end

         if (w_drop_set) begin
            r_drop_pend <= 1'b1;
         end else if (w_drop_clr) begin
            r_drop_pend <= 1'b0;
         end

         if (w_accept && r_out_is_trl) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
         end
      end
   end

   assign wen_o     = w_accept;
   assign wdata_o   = r_out_data;
   assign pkt_cnt_o = r_pkt_cnt;
   assign trunc_o   = r_trunc;
   assign busy_o    = (r_state != ST_IDLE) | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_afifo_pkt_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afifo_pkt_writer
//  Purpose  : Directed self-checking bench for afifo_pkt_writer
//             (WIDTH=8, MAX_LEN=4, CNT_W=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_afifo_pkt_writer;

   logic        wclk_i = 1'b0;
   logic        wrst_n_i = 1'b0;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic [7:0]  s_data_i = 8'h00;
   logic        s_last_i = 1'b0;
   logic        wen_o;
   logic [7:0]  wdata_o;
   logic        wfull_i = 1'b0;
   logic [15:0] pkt_cnt_o;
   logic        trunc_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_err = 0;

   // FIFO write log filled by the monitor only
   logic [7:0] q_word[$];
   int         q_cyc[$];
   int         cyc = 0;
   int         trunc_cnt = 0;

   afifo_pkt_writer #(.WIDTH(8), .MAX_LEN(4), .CNT_W(16)) u_dut (
      .wclk_i    (wclk_i),
      .wrst_n_i  (wrst_n_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_data_i  (s_data_i),
      .s_last_i  (s_last_i),
      .wen_o     (wen_o),
      .wdata_o   (wdata_o),
      .wfull_i   (wfull_i),
      .pkt_cnt_o (pkt_cnt_o),
      .trunc_o   (trunc_o),
      .busy_o    (busy_o)
   );

   always #5 wclk_i = ~wclk_i;

   always @(posedge wclk_i) cyc <= cyc + 1;

   always @(negedge wclk_i) begin
      if (wen_o) begin
         q_word.push_back(wdata_o);
         q_cyc.push_back(cyc);
      end
      if (trunc_o) trunc_cnt = trunc_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_beat(input logic [7:0] d, input logic l);
      int t = 0;
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = l;
      @(negedge wclk_i);
      while (!s_ready_o && t < 200) begin
         @(negedge wclk_i);
         t++;
      end
      if (t >= 200) check_val("beat_timeout", 32'(t), 32'd0);
      @(posedge wclk_i);
      #1;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge wclk_i);
      while (busy_o && t < 200) begin
         @(negedge wclk_i);
         t++;
      end
      if (t >= 200) check_val("idle_timeout", 32'(t), 32'd0);
      @(negedge wclk_i);
   endtask

   task automatic check_words(input string tag, input int base, input logic [7:0] exp[$]);
      check_val({tag, "_nwords"}, 32'(q_word.size() - base), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (base + i < q_word.size())
            check_val($sformatf("%s_w%0d", tag, i), 32'(q_word[base + i]), 32'(exp[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_wen"},   32'(wen_o),     32'd0);
      check_val({tag, "_wdata"}, 32'(wdata_o),   32'd0);
      check_val({tag, "_ready"}, 32'(s_ready_o), 32'd0);
      check_val({tag, "_cnt"},   32'(pkt_cnt_o), 32'd0);
      check_val({tag, "_trunc"}, 32'(trunc_o),   32'd0);
      check_val({tag, "_busy"},  32'(busy_o),    32'd0);
   endtask

   initial begin
      int base;
      int tbase;
      logic [7:0] exp[$];

      // ---------------- reset ----------------
      #1;
      check_reset_outputs("rst");
      repeat (3) @(posedge wclk_i);
      @(negedge wclk_i);
      wrst_n_i = 1'b1;

      // ---------------- basic frame ----------------
      base = q_word.size();
      @(posedge wclk_i); #1;
      drive_beat(8'h11, 1'b0);
      drive_beat(8'h22, 1'b0);
      drive_beat(8'h33, 1'b1);
      wait_idle();
      exp = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      check_words("basic", base, exp);
      if (q_cyc.size() >= base + 5)
         check_val("basic_span", 32'(q_cyc[base + 4] - q_cyc[base]), 32'd4);
      check_val("basic_cnt", 32'(pkt_cnt_o), 32'd1);

      // ---------------- backpressure ----------------
      base = q_word.size();
      fork
         begin
            drive_beat(8'h11, 1'b0);
            drive_beat(8'h22, 1'b0);
            drive_beat(8'h33, 1'b1);
         end
         begin
            int t = 0;
            @(negedge wclk_i);
            while (!(wen_o && wdata_o == 8'h11) && t < 100) begin
               @(negedge wclk_i);
               t++;
            end
            if (t >= 100) check_val("bp_timeout", 32'(t), 32'd0);
            @(posedge wclk_i); #1;
            wfull_i = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge wclk_i);
               check_val($sformatf("bp_wen%0d", k),   32'(wen_o),     32'd0);
               check_val($sformatf("bp_rdy%0d", k),   32'(s_ready_o), 32'd0);
               check_val($sformatf("bp_hold%0d", k),  32'(wdata_o),   32'h22);
            end
            @(posedge wclk_i); #1;
            wfull_i = 1'b0;
            #2;
            check_val("bp_resume_wen", 32'(wen_o), 32'd1);
         end
      join
      wait_idle();
      exp = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h00};
      check_words("bp", base, exp);
      check_val("bp_cnt", 32'(pkt_cnt_o), 32'd2);

      // ---------------- sequence wrap ----------------
      @(negedge wclk_i);
      wrst_n_i = 1'b0;
      @(negedge wclk_i);
      wrst_n_i = 1'b1;
      @(posedge wclk_i); #1;
      base = q_word.size();
      for (int p = 0; p < 257; p++) drive_beat(8'h5A, 1'b1);
      wait_idle();
      exp = {};
      for (int p = 0; p < 257; p++) begin
         exp.push_back(8'(p));
         exp.push_back(8'h5A);
         exp.push_back(8'h5A);
      end
      check_words("wrap", base, exp);
      check_val("wrap_cnt", 32'(pkt_cnt_o), 32'd257);

      // ---------------- truncation (MAX_LEN=4) ----------------
      base  = q_word.size();
      tbase = trunc_cnt;
      @(posedge wclk_i); #1;
      for (int b = 1; b <= 6; b++) drive_beat(8'(b), b == 6);
      wait_idle();
      exp = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      check_words("trunc", base, exp);
      check_val("trunc_pulses", 32'(trunc_cnt - tbase), 32'd1);
      check_val("trunc_cnt", 32'(pkt_cnt_o), 32'd258);
      check_val("trunc_busy", 32'(busy_o), 32'd0);

      // ---------------- reset mid-PAY ----------------
      @(posedge wclk_i); #1;
      drive_beat(8'hA1, 1'b0);
      drive_beat(8'hA2, 1'b0);
      #2;
      wrst_n_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge wclk_i);
      wrst_n_i = 1'b1;
      base = q_word.size();
      @(posedge wclk_i); #1;
      drive_beat(8'h77, 1'b1);
      wait_idle();
      exp = '{8'h00, 8'h77, 8'h77};
      check_words("postrst", base, exp);
      check_val("postrst_cnt", 32'(pkt_cnt_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, got running expected done");
      $fatal(1);
   end

endmodule
`default_nettype wire
